// File: rtl/audio_pkg.sv
// Shared constants for the audio codec serial interface.
// Channel encoding follows the LRCK level: low selects left, high selects right.
package audio_pkg;

    localparam int DATA_WIDTH_DEF  = 24;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous codec input.
// Also produces single-cycle rise/fall strobes of the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/audio_codec_if.sv
// Left-justified serial interface to an audio codec running as bus master.
// RX deserializes ADC pairs; TX serializes a one-deep buffered DAC pair.
module audio_codec_if
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic [DATA_WIDTH-1:0] adc_left,
    output logic [DATA_WIDTH-1:0] adc_right,
    output logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] dac_left,
    input  logic [DATA_WIDTH-1:0] dac_right,
    input  logic                  dac_valid,
    output logic                  dac_ready,
    output logic                  dac_underrun
);

    localparam int             CW   = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(DATA_WIDTH);

    logic bclk_s, bclk_rise, bclk_fall;
    logic adclrck_s, adcdat_s, daclrck_s;
    logic dac_lr_rise, dac_lr_fall;
    logic unused_bclk_s, unused_daclrck_s;
    logic unused_alr_rise, unused_alr_fall;
    logic unused_adat_rise, unused_adat_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .d_i    (AUD_BCLK),
        .q_o    (bclk_s),
        .rise_o (bclk_rise),
        .fall_o (bclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_adclrck (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .d_i    (AUD_ADCLRCK),
        .q_o    (adclrck_s),
        .rise_o (unused_alr_rise),
        .fall_o (unused_alr_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_adcdat (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .d_i    (AUD_ADCDAT),
        .q_o    (adcdat_s),
        .rise_o (unused_adat_rise),
        .fall_o (unused_adat_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_daclrck (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .d_i    (AUD_DACLRCK),
        .q_o    (daclrck_s),
        .rise_o (dac_lr_rise),
        .fall_o (dac_lr_fall)
    );

    assign unused_bclk_s    = bclk_s;
    assign unused_daclrck_s = daclrck_s;

    // ---------------- RX path ----------------
    logic                  rx_lr_q, rx_lr_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_lcap_q, rx_lcap_d;
    logic                  rx_pair_q, rx_pair_d;
    logic [DATA_WIDTH-1:0] adc_l_q, adc_l_d;
    logic [DATA_WIDTH-1:0] adc_r_q, adc_r_d;
    logic                  adc_valid_q, adc_valid_d;
    logic                  rx_edge, rx_done;

    always_comb begin
        rx_lr_d     = rx_lr_q;
        rx_cnt_d    = rx_cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_lcap_d   = rx_lcap_q;
        rx_pair_d   = rx_pair_q;
        adc_l_d     = adc_l_q;
        adc_r_d     = adc_r_q;
        adc_valid_d = 1'b0;
        rx_edge     = 1'b0;
        rx_done     = 1'b0;

        if (bclk_rise) begin
            rx_lr_d = adclrck_s;
            rx_edge = (adclrck_s != rx_lr_q);
            // A zero count means no slot start seen yet; stay idle.
            if (rx_edge) begin
                rx_cnt_d = {{(CW-1){1'b0}}, 1'b1};
                rx_sh_d  = {{(DATA_WIDTH-1){1'b0}}, adcdat_s};
            end else if (rx_cnt_q != '0 && rx_cnt_q < FULL) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                rx_sh_d  = {rx_sh_q[DATA_WIDTH-2:0], adcdat_s};
            end
            rx_done = (rx_cnt_d == FULL) && (rx_cnt_q != FULL);
        end

        if (rx_edge && adclrck_s == LEFT) begin
            rx_pair_d = 1'b0;
        end

        if (rx_done) begin
            if (rx_lr_d == RIGHT) begin
                if (rx_pair_q) begin
                    adc_l_d     = rx_lcap_q;
                    adc_r_d     = rx_sh_d;
                    adc_valid_d = 1'b1;
                end
                rx_pair_d = 1'b0;
            end else begin
                rx_lcap_d = rx_sh_d;
                rx_pair_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_lr_q     <= 1'b0;
            rx_cnt_q    <= '0;
            rx_sh_q     <= '0;
            rx_lcap_q   <= '0;
            rx_pair_q   <= 1'b0;
            adc_l_q     <= '0;
            adc_r_q     <= '0;
            adc_valid_q <= 1'b0;
        end else begin
            rx_lr_q     <= rx_lr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_lcap_q   <= rx_lcap_d;
            rx_pair_q   <= rx_pair_d;
            adc_l_q     <= adc_l_d;
            adc_r_q     <= adc_r_d;
            adc_valid_q <= adc_valid_d;
        end
    end

    assign adc_left  = adc_l_q;
    assign adc_right = adc_r_q;
    assign adc_valid = adc_valid_q;

    // ---------------- TX path ----------------
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d;
    logic [DATA_WIDTH-1:0] buf_r_q, buf_r_d;
    logic [DATA_WIDTH-1:0] tx_r_q, tx_r_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic                  dacdat_q, dacdat_d;
    logic                  under_q, under_d;
    logic                  tx_load, hs;
    logic [DATA_WIDTH-1:0] tx_word;

    assign hs = dac_valid & ~buf_full_q;

    always_comb begin
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        tx_r_d     = tx_r_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        dacdat_d   = dacdat_q;
        under_d    = 1'b0;
        tx_load    = 1'b0;
        tx_word    = '0;

        // Frame start drains the buffer; an empty buffer sends silence.
        if (dac_lr_fall) begin
            tx_load    = 1'b1;
            tx_word    = buf_full_q ? buf_l_q : '0;
            tx_r_d     = buf_full_q ? buf_r_q : '0;
            under_d    = ~buf_full_q;
            buf_full_d = 1'b0;
        end else if (dac_lr_rise) begin
            tx_load = 1'b1;
            tx_word = tx_r_q;
        end

        if (tx_load) begin
            dacdat_d = tx_word[DATA_WIDTH-1];
            tx_sh_d  = {tx_word[DATA_WIDTH-2:0], 1'b0};
            tx_cnt_d = {{(CW-1){1'b0}}, 1'b1};
        end else if (bclk_fall) begin
            if (tx_cnt_q != '0 && tx_cnt_q < FULL) begin
                dacdat_d = tx_sh_q[DATA_WIDTH-1];
                tx_sh_d  = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q + 1'b1;
            end else begin
                dacdat_d = 1'b0;
            end
        end

        if (hs) begin
            buf_full_d = 1'b1;
            buf_l_d    = dac_left;
            buf_r_d    = dac_right;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            tx_r_q     <= '0;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            dacdat_q   <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            tx_r_q     <= tx_r_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            dacdat_q   <= dacdat_d;
            under_q    <= under_d;
        end
    end

    assign AUD_DACDAT   = dacdat_q;
    assign dac_ready    = ~buf_full_q;
    assign dac_underrun = under_q;

endmodule

// File: tb/tb_audio_codec_if.sv
// Directed bench for audio_codec_if: BFM plays codec master, 64 BCLK/frame.
// Checks RX capture, TX serialization, buffering, underrun and reset.
module tb_audio_codec_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bclk = 1'b0;
    logic        adclrck = 1'b1;
    logic        adcdat = 1'b0;
    logic        daclrck = 1'b1;
    logic        dacdat;
    logic [23:0] adc_l, adc_r;
    logic        adc_v;
    logic [23:0] dac_l, dac_r;
    logic        dac_v;
    logic        rdy, und;
    logic [23:0] tb_dl = '0, tb_dr = '0;
    logic        tb_dv = 1'b0;
    logic        loop_en = 1'b0;

    assign dac_l = loop_en ? adc_l : tb_dl;
    assign dac_r = loop_en ? adc_r : tb_dr;
    assign dac_v = loop_en ? adc_v : tb_dv;

    always #5 clk = ~clk;

    audio_codec_if #(.DATA_WIDTH(24), .SYNC_STAGES(2)) dut (
        .CLOCK_50     (clk),
        .reset_n      (rst_n),
        .AUD_BCLK     (bclk),
        .AUD_ADCLRCK  (adclrck),
        .AUD_ADCDAT   (adcdat),
        .AUD_DACLRCK  (daclrck),
        .AUD_DACDAT   (dacdat),
        .adc_left     (adc_l),
        .adc_right    (adc_r),
        .adc_valid    (adc_v),
        .dac_left     (dac_l),
        .dac_right    (dac_r),
        .dac_valid    (dac_v),
        .dac_ready    (rdy),
        .dac_underrun (und)
    );

    int n_total = 0;
    int n_bad   = 0;
    int v_cnt   = 0;
    int u_cnt   = 0;
    int v0, u0;
    logic [31:0] cap_l, cap_r;
    logic        any_bit;

    always @(negedge clk) begin
        if (adc_v) v_cnt++;
        if (und) u_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk({tag, "_adc_left"}, adc_l, 0);
        chk({tag, "_adc_right"}, adc_r, 0);
        chk({tag, "_adc_valid"}, adc_v, 0);
        chk({tag, "_dacdat"}, dacdat, 0);
        chk({tag, "_underrun"}, und, 0);
        chk({tag, "_ready"}, rdy, 1);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        tb_dl = l;
        tb_dr = r;
        tb_dv = 1'b1;
        @(negedge clk);
        tb_dv = 1'b0;
        @(negedge clk);
    endtask

    // LRCK and data change with the BCLK falling edge; DACDAT is
    // sampled at the BCLK rising edge, as the codec would.
    task automatic frame(input logic [23:0] l, input logic [23:0] r,
                         input int lbits, input int rbits,
                         input int rst_at);
        logic [23:0] w;
        int          n;
        cap_l = '0;
        cap_r = '0;
        for (int ch = 0; ch < 2; ch++) begin
            w = (ch == 0) ? l : r;
            n = (ch == 0) ? lbits : rbits;
            for (int b = 0; b < n; b++) begin
                if (ch == 1 && b == rst_at) do_reset("midrst");
                bclk = 1'b0;
                if (b == 0) begin
                    adclrck = (ch == 1);
                    daclrck = (ch == 1);
                end
                adcdat = (b < 24) ? w[23-b] : 1'b1;
                repeat (4) @(negedge clk);
                bclk = 1'b1;
                if (ch == 0) cap_l[31-b] = dacdat;
                else         cap_r[31-b] = dacdat;
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic idle_bits(input int n);
        for (int b = 0; b < n; b++) begin
            bclk = 1'b0;
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset("init");
        repeat (4) @(negedge clk);
        idle_bits(4);

        // ADC pairs every frame; DAC never fed -> underrun each frame
        v0 = v_cnt;
        u0 = u_cnt;
        any_bit = 1'b0;
        repeat (3) begin
            frame(24'hA5A5A5, 24'h5A5A5A, 32, 32, -1);
            if ((cap_l | cap_r) != 0) any_bit = 1'b1;
        end
        chk("s1_valid_cnt", v_cnt - v0, 3);
        chk("s1_adc_left", adc_l, 24'hA5A5A5);
        chk("s1_adc_right", adc_r, 24'h5A5A5A);
        chk("s3_underruns", u_cnt - u0, 3);
        chk("s3_dac_zero", any_bit, 0);

        // Preloaded pair goes out MSB first with zero padding
        chk("s2_ready_empty", rdy, 1);
        push(24'h800001, 24'h7FFFFF);
        chk("s2_ready_full", rdy, 0);
        u0 = u_cnt;
        frame(24'h111111, 24'h222222, 32, 32, -1);
        chk("s2_dac_left", cap_l, {24'h800001, 8'h00});
        chk("s2_dac_right", cap_r, {24'h7FFFFF, 8'h00});
        chk("s2_ready_after", rdy, 1);
        chk("s2_no_underrun", u_cnt - u0, 0);
        chk("s2_adc_left", adc_l, 24'h111111);
        chk("s2_adc_right", adc_r, 24'h222222);

        // Second pair waits while the buffer is full
        push(24'hABCDEF, 24'h123456);
        tb_dl = 24'h0F0F0F;
        tb_dr = 24'hF0F0F0;
        tb_dv = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6_ready_held", rdy, 0);
        u0 = u_cnt;
        frame(24'h000000, 24'hFFFFFF, 32, 32, -1);
        chk("s6_first_left", cap_l, {24'hABCDEF, 8'h00});
        chk("s6_first_right", cap_r, {24'h123456, 8'h00});
        chk("s6_second_taken", rdy, 0);
        tb_dv = 1'b0;
        frame(24'h000000, 24'hFFFFFF, 32, 32, -1);
        chk("s6_second_left", cap_l, {24'h0F0F0F, 8'h00});
        chk("s6_second_right", cap_r, {24'hF0F0F0, 8'h00});
        chk("s6_no_underrun", u_cnt - u0, 0);

        // Reset mid right slot, then short slots
        v0 = v_cnt;
        frame(24'h123456, 24'h654321, 32, 32, 10);
        chk("s4_no_valid_rst", v_cnt - v0, 0);
        frame(24'h13579B, 24'h2468AC, 32, 32, -1);
        chk("s4_valid_after", v_cnt - v0, 1);
        chk("s4_adc_left", adc_l, 24'h13579B);
        chk("s4_adc_right", adc_r, 24'h2468AC);
        v0 = v_cnt;
        frame(24'h0C0C0C, 24'h303030, 12, 32, -1);
        chk("short_left_valid", v_cnt - v0, 0);
        frame(24'h0D0D0D, 24'h404040, 32, 12, -1);
        chk("short_right_valid", v_cnt - v0, 0);
        chk("short_keep_left", adc_l, 24'h13579B);
        frame(24'h9ABCDE, 24'h876543, 32, 32, -1);
        chk("short_recover_cnt", v_cnt - v0, 1);
        chk("short_recover_l", adc_l, 24'h9ABCDE);

        // Loopback: DAC repeats ADC one frame later
        loop_en = 1'b1;
        frame(24'hC0FFEE, 24'hBADA55, 32, 32, -1);
        u0 = u_cnt;
        frame(24'h010203, 24'h040506, 32, 32, -1);
        chk("s5_left_1", cap_l, {24'hC0FFEE, 8'h00});
        chk("s5_right_1", cap_r, {24'hBADA55, 8'h00});
        frame(24'hFEDCBA, 24'h0A0B0C, 32, 32, -1);
        chk("s5_left_2", cap_l, {24'h010203, 8'h00});
        chk("s5_right_2", cap_r, {24'h040506, 8'h00});
        chk("s5_no_underrun", u_cnt - u0, 0);
        loop_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
